// File: rtl/ccip_mem_responder_pkg.sv
// Purpose: CCI-P channel types plus responder queue/pipe entry types.
// Latency: n/a (types and helpers only).
// Backpressure: n/a; c0TxAlmFull is the only flow-control signal.
package ccip_mem_responder_pkg;

  typedef logic [511:0] t_ccip_clData;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [41:0]  t_ccip_clAddr;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  // Read-response queue entry: captured line, tag, and acceptance timestamp.
  typedef struct packed {
    t_ccip_clData data;
    t_ccip_mdata  mdata;
    logic [15:0]  ts;
  } t_rd_entry;

  // One stage of the fixed-latency write-response pipe.
  typedef struct packed {
    logic        valid;
    t_ccip_mdata mdata;
  } t_wr_pipe_entry;

  // Age of a queued read in cycles; wraps modulo 2^16 like the timestamp.
  function automatic logic [15:0] ts_age(input logic [15:0] now, input logic [15:0] ts);
    return now - ts;
  endfunction

endpackage

// File: rtl/ccip_rsp_fifo.sv
// Purpose: generic synchronous FIFO holding pending read responses.
// Latency: an entry written at an edge is at the head from the next cycle.
// Backpressure: caller must not enq when full unless deq in the same cycle.
module ccip_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq_en,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq_en,
  output logic [WIDTH-1:0]         first,
  output logic                     not_full,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      r_mem[r_wr_ptr] <= enq_data;
    end
  end

  // Pointers and occupancy; a pop on a full queue frees the slot for a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (enq_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (deq_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({enq_en, deq_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign first     = r_mem[r_rd_ptr];
  assign not_full  = (r_count != CW'(DEPTH));
  assign not_empty = (r_count != '0);
  assign count     = r_count;

endmodule

// File: rtl/ccip_mem_responder.sv
// Purpose: CCI-P host-memory stand-in: line memory serving c0 reads and c1 writes.
// Latency: reads >= RD_LATENCY cycles (spaced by RSP_GAP); writes exactly WR_LATENCY.
// Backpressure: c0TxAlmFull near queue full; reads arriving on a full queue are dropped.
module ccip_mem_responder
  import ccip_mem_responder_pkg::*;
#(
  parameter int MEM_LINES       = 256,
  parameter int RD_FIFO_DEPTH   = 16,
  parameter int ALM_FULL_MARGIN = 4,
  parameter int RD_LATENCY      = 8,
  parameter int RSP_GAP         = 1,
  parameter int WR_LATENCY      = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_if_ccip_c0_Tx ccip_c0_tx,
  input  t_if_ccip_c1_Tx ccip_c1_tx,
  output t_if_ccip_Rx    ccip_rx,
  output logic           err_overflow,
  output logic           err_cl_len
);

  localparam int IDX_W      = $clog2(MEM_LINES);
  localparam int CNT_W      = $clog2(RD_FIFO_DEPTH) + 1;
  localparam int ALM_THRESH = RD_FIFO_DEPTH - ALM_FULL_MARGIN;
  localparam logic [15:0] RD_LAT16     = 16'(RD_LATENCY);
  localparam logic [15:0] GAP_RELOAD16 = 16'(RSP_GAP - 1);

  logic [511:0]     r_mem [MEM_LINES];
  logic [15:0]      r_now;
  logic [15:0]      r_gap;
  logic             r_alm_full;
  logic             r_c0_vld;
  t_ccip_mdata      r_c0_mdata;
  t_ccip_clData     r_c0_data;
  t_wr_pipe_entry   r_wr_pipe [WR_LATENCY];
  logic             r_err_overflow;
  logic             r_err_cl_len;

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  t_rd_entry        w_push_entry;
  t_rd_entry        w_head;
  logic             w_not_full;
  logic             w_not_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_ripe;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_unused_hdr;

  assign w_rd_idx = ccip_c0_tx.hdr.address[IDX_W-1:0];
  assign w_wr_idx = ccip_c1_tx.hdr.address[IDX_W-1:0];

  // Header fields this responder deliberately ignores (vc, sop, req_type, upper address).
  assign w_unused_hdr = ^{ccip_c0_tx.hdr, ccip_c1_tx.hdr};

  // Line memory write; a same-cycle read sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (ccip_c1_tx.valid) begin
      r_mem[w_wr_idx] <= ccip_c1_tx.data;
    end
  end

  // Capture the line, tag and acceptance time for the read being accepted now.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.data  = r_mem[w_rd_idx];
    w_push_entry.mdata = ccip_c0_tx.hdr.mdata;
    w_push_entry.ts    = r_now;
  end

  // The registered response lands one cycle after the pop decision, so age is
  // measured at that landing cycle (r_now + 1) against the acceptance cycle.
  assign w_ripe = (ts_age(r_now + 16'd1, w_head.ts) >= RD_LAT16);
  assign w_pop  = w_not_empty && w_ripe && (r_gap == '0);
  assign w_push = ccip_c0_tx.valid && (w_not_full || w_pop);
  assign w_drop = ccip_c0_tx.valid && !w_not_full && !w_pop;

  ccip_rsp_fifo #(
    .WIDTH ($bits(t_rd_entry)),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq_en    (w_push),
    .enq_data  (w_push_entry),
    .deq_en    (w_pop),
    .first     (w_head),
    .not_full  (w_not_full),
    .not_empty (w_not_empty),
    .count     (w_count)
  );

  // Free-running timestamp base.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_now <= '0;
    end else begin
      r_now <= r_now + 16'd1;
    end
  end

  // Response spacing: reload on every pop, count down to zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap <= '0;
    end else if (w_pop) begin
      r_gap <= GAP_RELOAD16;
    end else if (r_gap != '0) begin
      r_gap <= r_gap - 16'd1;
    end
  end

  // Almost-full follows the occupancy that was in place during this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alm_full <= 1'b0;
    end else begin
      r_alm_full <= (w_count >= CNT_W'(ALM_THRESH));
    end
  end

  // Registered read response taken from the queue head on pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c0_vld   <= 1'b0;
      r_c0_mdata <= '0;
      r_c0_data  <= '0;
    end else begin
      r_c0_vld <= w_pop;
      if (w_pop) begin
        r_c0_mdata <= w_head.mdata;
        r_c0_data  <= w_head.data;
      end
    end
  end

  // Write-response shift pipe; the last stage drives c1 directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WR_LATENCY; i++) begin
        r_wr_pipe[i] <= '0;
      end
    end else begin
      r_wr_pipe[0].valid <= ccip_c1_tx.valid;
      r_wr_pipe[0].mdata <= ccip_c1_tx.hdr.mdata;
      for (int i = 1; i < WR_LATENCY; i++) begin
        r_wr_pipe[i] <= r_wr_pipe[i-1];
      end
    end
  end

  // Sticky error flags: dropped read, and multi-line requests served as one line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_overflow <= 1'b0;
      r_err_cl_len   <= 1'b0;
    end else begin
      if (w_drop) r_err_overflow <= 1'b1;
      if ((ccip_c0_tx.valid && (ccip_c0_tx.hdr.cl_len != eCL_LEN_1)) ||
          (ccip_c1_tx.valid && (ccip_c1_tx.hdr.cl_len != eCL_LEN_1))) begin
        r_err_cl_len <= 1'b1;
      end
    end
  end

  // Assemble the Rx bundle purely from registers; unused fields stay zero.
  always_comb begin
    ccip_rx                  = '0;
    ccip_rx.c0TxAlmFull      = r_alm_full;
    ccip_rx.c0.rspValid      = r_c0_vld;
    ccip_rx.c0.hdr.resp_type = eRSP_RDLINE;
    ccip_rx.c0.hdr.mdata     = r_c0_mdata;
    ccip_rx.c0.data          = r_c0_data;
    ccip_rx.c1.rspValid      = r_wr_pipe[WR_LATENCY-1].valid;
    ccip_rx.c1.hdr.resp_type = eRSP_WRLINE;
    ccip_rx.c1.hdr.mdata     = r_wr_pipe[WR_LATENCY-1].mdata;
  end

  assign err_overflow = r_err_overflow;
  assign err_cl_len   = r_err_cl_len;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Purpose: directed self-checking bench for ccip_mem_responder (two parameterizations).
// Latency: expected response cycles are hand-derived from acceptance cycles.
// Backpressure: overflow exercised on a long-latency instance that never drains in time.
module tb_ccip_mem_responder;
  import ccip_mem_responder_pkg::*;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  t_if_ccip_c0_Tx c0_tx;
  t_if_ccip_c1_Tx c1_tx;
  t_if_ccip_Rx    rx, rx2;
  logic           err_ovf, err_cl, err_ovf2, err_cl2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0]  r_md[$];
  int           r_cy[$];
  logic [511:0] r_dt[$];
  logic [3:0]   r_ty[$];
  logic [1:0]   r_cl[$];
  logic [15:0]  w_md[$];
  int           w_cy[$];
  logic [15:0]  s_md[$];
  logic         alm_hist [0:8191];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ccip_mem_responder #(
    .MEM_LINES(256), .RD_FIFO_DEPTH(16), .ALM_FULL_MARGIN(4),
    .RD_LATENCY(8), .RSP_GAP(3), .WR_LATENCY(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ccip_c0_tx(c0_tx), .ccip_c1_tx(c1_tx),
    .ccip_rx(rx), .err_overflow(err_ovf), .err_cl_len(err_cl)
  );

  ccip_mem_responder #(
    .MEM_LINES(256), .RD_FIFO_DEPTH(16), .ALM_FULL_MARGIN(4),
    .RD_LATENCY(200), .RSP_GAP(1), .WR_LATENCY(4)
  ) dut_slow (
    .clk(clk), .reset_n(reset_n), .ccip_c0_tx(c0_tx), .ccip_c1_tx(c1_tx),
    .ccip_rx(rx2), .err_overflow(err_ovf2), .err_cl_len(err_cl2)
  );

  // Response logger, sampled mid-cycle.
  always @(negedge clk) begin
    alm_hist[cyc % 8192] = rx.c0TxAlmFull;
    if (rx.c0.rspValid) begin
      r_md.push_back(rx.c0.hdr.mdata);
      r_cy.push_back(cyc);
      r_dt.push_back(rx.c0.data);
      r_ty.push_back(rx.c0.hdr.resp_type);
      r_cl.push_back(rx.c0.hdr.cl_num);
    end
    if (rx.c1.rspValid) begin
      w_md.push_back(rx.c1.hdr.mdata);
      w_cy.push_back(cyc);
    end
    if (rx2.c0.rspValid) s_md.push_back(rx2.c0.hdr.mdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c0_tx = '0;
    c1_tx = '0;
  endtask

  task automatic clear_logs();
    r_md.delete(); r_cy.delete(); r_dt.delete(); r_ty.delete(); r_cl.delete();
    w_md.delete(); w_cy.delete(); s_md.delete();
  endtask

  task automatic drive_rd(input logic [41:0] a, input logic [15:0] md, input t_ccip_clLen len);
    c0_tx = '0;
    c0_tx.valid = 1'b1;
    c0_tx.hdr.address = a;
    c0_tx.hdr.mdata = md;
    c0_tx.hdr.cl_len = len;
    c0_tx.hdr.req_type = eREQ_RDLINE_I;
  endtask

  task automatic drive_wr(input logic [41:0] a, input logic [15:0] md, input logic [511:0] d);
    c1_tx = '0;
    c1_tx.valid = 1'b1;
    c1_tx.hdr.address = a;
    c1_tx.hdr.mdata = md;
    c1_tx.hdr.cl_len = eCL_LEN_1;
    c1_tx.hdr.sop = 1'b1;
    c1_tx.hdr.req_type = eREQ_WRLINE_I;
    c1_tx.data = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx.c0.rspValid !== 1'b0) begin errors++; $display("FAIL reset_c0_vld: got %b expected 0", rx.c0.rspValid); end
    checks++; if (rx.c1.rspValid !== 1'b0) begin errors++; $display("FAIL reset_c1_vld: got %b expected 0", rx.c1.rspValid); end
    checks++; if (rx.c0TxAlmFull !== 1'b0) begin errors++; $display("FAIL reset_alm: got %b expected 0", rx.c0TxAlmFull); end
    checks++; if ({err_ovf, err_cl} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {err_ovf, err_cl}); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int acc;
    logic [511:0] got_d;
    drive_wr(42'd3, 16'd1, 512'hA5);
    tick(); idle();
    repeat (8) tick();
    clear_logs();
    drive_rd(42'd3, 16'd7, eCL_LEN_1);
    acc = cyc;
    tick(); idle();
    repeat (14) tick();
    got_d = (r_dt.size() > 0) ? r_dt[0] : 'x;
    checks++; if (r_md.size() !== 1) begin errors++; $display("FAIL rd1_count: got %0d expected 1", r_md.size()); end
    checks++; if (((r_cy.size() > 0) ? r_cy[0] : -1) !== acc + 8) begin errors++; $display("FAIL rd1_latency: got cycle %0d expected %0d", (r_cy.size() > 0) ? r_cy[0] : -1, acc + 8); end
    checks++; if (got_d !== 512'hA5) begin errors++; $display("FAIL rd1_data: got %h expected a5", got_d[31:0]); end
    checks++; if (((r_md.size() > 0) ? r_md[0] : 16'hxxxx) !== 16'd7) begin errors++; $display("FAIL rd1_mdata: got %0d expected 7", (r_md.size() > 0) ? r_md[0] : 16'hxxxx); end
    checks++; if (((r_ty.size() > 0) ? r_ty[0] : 4'hx) !== eRSP_RDLINE) begin errors++; $display("FAIL rd1_type: got %h expected %h", (r_ty.size() > 0) ? r_ty[0] : 4'hx, eRSP_RDLINE); end
    checks++; if (((r_cl.size() > 0) ? r_cl[0] : 2'bxx) !== 2'd0) begin errors++; $display("FAIL rd1_cl_num: got %0d expected 0", (r_cl.size() > 0) ? r_cl[0] : 2'bxx); end
  endtask

  task automatic test_write_then_read();
    int a;
    logic [511:0] got_d;
    clear_logs();
    drive_wr(42'd5, 16'd2, 512'h1234);
    a = cyc;
    tick(); idle();
    drive_rd(42'd5, 16'd3, eCL_LEN_1);
    tick(); idle();
    repeat (15) tick();
    got_d = (r_dt.size() > 0) ? r_dt[0] : 'x;
    checks++; if (w_md.size() !== 1) begin errors++; $display("FAIL wr_count: got %0d expected 1", w_md.size()); end
    checks++; if (((w_cy.size() > 0) ? w_cy[0] : -1) !== a + 4) begin errors++; $display("FAIL wr_latency: got cycle %0d expected %0d", (w_cy.size() > 0) ? w_cy[0] : -1, a + 4); end
    checks++; if (((w_md.size() > 0) ? w_md[0] : 16'hxxxx) !== 16'd2) begin errors++; $display("FAIL wr_mdata: got %0d expected 2", (w_md.size() > 0) ? w_md[0] : 16'hxxxx); end
    checks++; if (got_d !== 512'h1234) begin errors++; $display("FAIL wr_readback: got %h expected 1234", got_d[31:0]); end
    checks++; if (((r_cy.size() > 0) ? r_cy[0] : -1) !== a + 9) begin errors++; $display("FAIL wr_readback_cycle: got %0d expected %0d", (r_cy.size() > 0) ? r_cy[0] : -1, a + 9); end
  endtask

  task automatic test_back_to_back();
    int c;
    clear_logs();
    tick();
    c = cyc;
    for (int j = 0; j < 16; j++) begin
      drive_rd(42'(j), 16'(100 + j), eCL_LEN_1);
      tick();
    end
    idle();
    repeat (60) tick();
    checks++; if (r_md.size() !== 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", r_md.size()); end
    for (int j = 0; j < 16; j++) begin
      checks++; if (((r_md.size() > j) ? r_md[j] : 16'hxxxx) !== 16'(100 + j)) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", j, (r_md.size() > j) ? r_md[j] : 16'hxxxx, 100 + j); end
      checks++; if (((r_cy.size() > j) ? r_cy[j] : -1) !== c + 8 + 3 * j) begin errors++; $display("FAIL b2b_spacing[%0d]: got cycle %0d expected %0d", j, (r_cy.size() > j) ? r_cy[j] : -1, c + 8 + 3 * j); end
    end
    // Occupancy first reaches 12 in cycle c+15 and last holds 12 in c+19.
    checks++; if (alm_hist[(c + 15) % 8192] !== 1'b0) begin errors++; $display("FAIL alm_before_rise: got %b expected 0", alm_hist[(c + 15) % 8192]); end
    checks++; if (alm_hist[(c + 16) % 8192] !== 1'b1) begin errors++; $display("FAIL alm_rise: got %b expected 1", alm_hist[(c + 16) % 8192]); end
    checks++; if (alm_hist[(c + 20) % 8192] !== 1'b1) begin errors++; $display("FAIL alm_hold: got %b expected 1", alm_hist[(c + 20) % 8192]); end
    checks++; if (alm_hist[(c + 21) % 8192] !== 1'b0) begin errors++; $display("FAIL alm_fall: got %b expected 0", alm_hist[(c + 21) % 8192]); end
  endtask

  task automatic test_same_cycle_rw();
    logic [511:0] d0, d1;
    drive_wr(42'd9, 16'd19, 512'h0);
    tick(); idle();
    repeat (6) tick();
    clear_logs();
    drive_rd(42'd9, 16'd20, eCL_LEN_1);
    drive_wr(42'd9, 16'd21, 512'hFF);
    tick(); idle();
    tick();
    drive_rd(42'd9, 16'd22, eCL_LEN_1);
    tick(); idle();
    repeat (20) tick();
    d0 = (r_dt.size() > 0) ? r_dt[0] : 'x;
    d1 = (r_dt.size() > 1) ? r_dt[1] : 'x;
    checks++; if (r_md.size() !== 2) begin errors++; $display("FAIL rw_count: got %0d expected 2", r_md.size()); end
    checks++; if (d0 !== 512'h0) begin errors++; $display("FAIL rw_old_data: got %h expected 0", d0[31:0]); end
    checks++; if (((r_md.size() > 0) ? r_md[0] : 16'hxxxx) !== 16'd20) begin errors++; $display("FAIL rw_old_mdata: got %0d expected 20", (r_md.size() > 0) ? r_md[0] : 16'hxxxx); end
    checks++; if (d1 !== 512'hFF) begin errors++; $display("FAIL rw_new_data: got %h expected ff", d1[31:0]); end
    checks++; if (((w_md.size() > 0) ? w_md[0] : 16'hxxxx) !== 16'd21) begin errors++; $display("FAIL rw_wr_mdata: got %0d expected 21", (w_md.size() > 0) ? w_md[0] : 16'hxxxx); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    clear_logs();
    for (int j = 0; j < 17; j++) begin
      drive_rd(42'(j), 16'(j), eCL_LEN_1);
      tick();
    end
    idle();
    tick();
    checks++; if (err_ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", err_ovf2); end
    checks++; if (rx2.c0TxAlmFull !== 1'b1) begin errors++; $display("FAIL ovf_alm: got %b expected 1", rx2.c0TxAlmFull); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_fast_flag: got %b expected 0", err_ovf); end
    repeat (300) tick();
    checks++; if (s_md.size() !== 16) begin errors++; $display("FAIL ovf_rsp_count: got %0d expected 16", s_md.size()); end
    checks++; if (((s_md.size() > 0) ? s_md[s_md.size() - 1] : 16'hxxxx) !== 16'd15) begin errors++; $display("FAIL ovf_last_mdata: got %0d expected 15", (s_md.size() > 0) ? s_md[s_md.size() - 1] : 16'hxxxx); end
    checks++; if (r_md.size() !== 17) begin errors++; $display("FAIL ovf_fast_count: got %0d expected 17", r_md.size()); end
  endtask

  task automatic test_reset_inflight();
    clear_logs();
    for (int j = 0; j < 5; j++) begin
      drive_rd(42'(j), 16'(50 + j), (j == 1) ? eCL_LEN_2 : eCL_LEN_1);
      if (j == 4) drive_wr(42'd7, 16'd60, 512'h77);
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (err_cl !== 1'b1) begin errors++; $display("FAIL cl_len_flag: got %b expected 1", err_cl); end
    pulse_reset();
    repeat (40) tick();
    checks++; if (r_md.size() !== 0) begin errors++; $display("FAIL inflight_c0: got %0d responses expected 0", r_md.size()); end
    checks++; if (w_md.size() !== 0) begin errors++; $display("FAIL inflight_c1: got %0d responses expected 0", w_md.size()); end
    checks++; if (rx.c0TxAlmFull !== 1'b0) begin errors++; $display("FAIL inflight_alm: got %b expected 0", rx.c0TxAlmFull); end
    checks++; if (err_cl !== 1'b0) begin errors++; $display("FAIL inflight_cl_clear: got %b expected 0", err_cl); end
    checks++; if (err_ovf2 !== 1'b0) begin errors++; $display("FAIL inflight_ovf_clear: got %b expected 0", err_ovf2); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_write_then_read();
    test_back_to_back();
    test_same_cycle_rw();
    test_overflow();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccip_mem_responder.md
# ccip_mem_responder

Synthesizable CCI-P host-memory responder: the far end of the `ccip_c0_tx`/`ccip_c1_tx` request channels that accelerator requestors drive. It holds a small on-chip line memory, services single-line reads and writes with configurable latency and response throttling, and drives `t_if_ccip_Rx`, including `c0TxAlmFull`. Used in simulation and loopback builds so requestor FSMs (key fetch, block streaming, DSM completion write) run without a host.

## Interface
- `MEM_LINES`, 256: memory depth in 512-bit lines; power of two.
- `RD_FIFO_DEPTH`, 16: read-response queue entries; power of two, ≥4.
- `ALM_FULL_MARGIN`, 4: `c0TxAlmFull` asserts when occupancy ≥ `RD_FIFO_DEPTH - ALM_FULL_MARGIN`.
- `RD_LATENCY`, 8: minimum cycles from read acceptance to response; 1..2^15-1.
- `RSP_GAP`, 1: minimum cycles between consecutive read responses; 1 = back-to-back.
- `WR_LATENCY`, 4: fixed cycles from write acceptance to write response; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ccip_c0_tx`  in  `t_if_ccip_c0_Tx`  read requests.
- `ccip_c1_tx`  in  `t_if_ccip_c1_Tx`  write requests.
- `ccip_rx`  out  `t_if_ccip_Rx`  responses and almost-full flags.
- `err_overflow`  out  1  sticky: read accepted while queue full.
- `err_cl_len`  out  1  sticky: request with `cl_len != eCL_LEN_1`.

## Operation
- Line index = `address[$clog2(MEM_LINES)-1:0]`; upper bits ignored (aliasing is intentional).
- Read: on `ccip_c0_tx.valid`, read memory in the same cycle. Push {data, `mdata`, timestamp} into the queue. A same-cycle write to the same line is **not** visible (old data returned).
- Write: on `ccip_c1_tx.valid`, write `data` to the line at that edge. Push `mdata` into a `WR_LATENCY`-stage shift pipe.
- `sop`, `vc_sel`, `req_type` are not checked. `cl_len != eCL_LEN_1` sets `err_cl_len` and is serviced as one line.
- Read drain: the head pops when both hold:
  - `(now - ts) ≥ RD_LATENCY`, with a 16-bit free-running `now` and modulo subtraction;
  - gap counter = 0.
- On pop: `ccip_rx.c0.rspValid=1`, `hdr.resp_type=eRSP_RDLINE`, `hdr.mdata` echoed, `hdr.cl_num=0`, `data` = captured line. The gap counter reloads to `RSP_GAP-1`.
- Write response: when the pipe output is valid, `ccip_rx.c1.rspValid=1`, `resp_type=eRSP_WRLINE`, `mdata` echoed, `format=0`, `cl_num=0`.
- Full queue: the request is dropped (no response), `err_overflow` set, and the queue is unchanged.
- Push and pop in the same cycle on a full queue: the pop frees the slot first, so the push succeeds.
- `c1TxAlmFull`, `c2` MMIO fields and `mmioRdValid`/`mmioWrValid` are held 0.
- Responses are in order per channel. c0 and c1 are independent and may respond in the same cycle.

## Timing
- Reset (`reset_n`=0, asynchronous): all `rspValid`=0, `c0TxAlmFull`=0, error flags=0, queue empty, `now`=0, gap=0, write pipe cleared.
  - Memory contents are not reset.
  - In-flight requests are discarded; no responses appear after release.
- Read latency: first response in cycle `accept + RD_LATENCY` when the queue is otherwise idle. A later head waits for its predecessors and the gap.
- `c0TxAlmFull` is registered: it reflects occupancy at the previous edge.
  - Requestors honouring it must not overflow while `ALM_FULL_MARGIN ≥ 2`.
- Write response at exactly `accept + WR_LATENCY`, one per cycle, unthrottled.
- Response outputs are registered; no combinational path from `ccip_c*_tx` to `ccip_rx`.

## Structure
- Shared package `ccip_mem_responder_pkg`:
  - `t_rd_entry` {data `t_ccip_clData`, mdata `t_ccip_mdata`, ts logic[15:0]};
  - `t_wr_pipe_entry` {valid, mdata}.
- One sub-module: `ccip_rsp_fifo`, a parameterized synchronous FIFO with `enq_en`/`deq_en`, `not_full`/`not_empty` and an occupancy `count` output, reset by `reset_n`.
- Memory as an inferred `logic [511:0] mem[MEM_LINES]`.

## Test plan
- Reset, then one read to line 3 preloaded with `'hA5`, `mdata=7` → exactly one `c0.rspValid` 8 cycles later with data `'hA5`, mdata 7, `eRSP_RDLINE`.
- Write `'h1234` to line 5 (`mdata=2`) → `c1.rspValid` 4 cycles later with mdata 2. A read of line 5 in the following cycle returns `'h1234`.
- 16 back-to-back reads with `RSP_GAP=3` → responses in order, spaced exactly 3 cycles. `c0TxAlmFull` rises the cycle after occupancy reaches 12 and falls after it drops below 12.
- 17 reads with no drain (`RD_LATENCY` large) → 17th dropped, `err_overflow`=1, 16 responses total.
- Same-cycle read and write to line 9 (old `'h0`, new `'hFF`) → read returns `'h0`; a later read returns `'hFF`.
- `reset_n` pulsed low with 5 reads in flight → no `c0.rspValid` after release, `c0TxAlmFull`=0, flags cleared.
